// File: rtl/zion_basic_circuit_lib_pipe_dff.sv
//==============================================================================
// Module   : zion_basic_circuit_lib_pipe_dff
// Brief    : Multi-stage valid/ready pipeline register with bubble collapsing.
// Revision : 1.0
//==============================================================================
`default_nettype none

module zion_basic_circuit_lib_pipe_dff #(
    parameter int              WIDTH    = 8,
    parameter int              DEPTH    = 2,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [CW-1:0]    oCnt
);

    if (WIDTH < 1) begin : g_chk_width
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_pipe_dff: WIDTH must be >= 1");
`else
        $error("zion_basic_circuit_lib_pipe_dff: WIDTH must be >= 1");
`endif
    end

    if (DEPTH < 1) begin : g_chk_depth
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_pipe_dff: DEPTH must be >= 1");
`else
        $error("zion_basic_circuit_lib_pipe_dff: DEPTH must be >= 1");
`endif
    end

    if ($bits(INI_DATA) > WIDTH) begin : g_chk_ini
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_pipe_dff: INI_DATA wider than WIDTH");
`else
        $error("zion_basic_circuit_lib_pipe_dff: INI_DATA wider than WIDTH");
`endif
    end

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            vld_d;
    logic [DEPTH-1:0][WIDTH-1:0] dat_q;
    logic [DEPTH-1:0][WIDTH-1:0] dat_d;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0]            prv_vld;
    logic [DEPTH-1:0][WIDTH-1:0] prv_dat;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               cnt_d;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // A stage can load if any stage at or after it is empty, or downstream takes a beat.
        assign rdy[k] = iRdy | ~(&vld_q[DEPTH-1:k]);

        if (k == 0) begin : g_head
            assign prv_vld[k] = iVld & ~flush;
            assign prv_dat[k] = iDat;
        end else begin : g_body
            assign prv_vld[k] = vld_q[k-1];
            assign prv_dat[k] = dat_q[k-1];
        end

        always_comb begin
            vld_d[k] = vld_q[k];
            dat_d[k] = dat_q[k];
            if (flush) begin
                vld_d[k] = 1'b0;
            end else if (rdy[k]) begin
                vld_d[k] = prv_vld[k];
                if (prv_vld[k]) begin
                    dat_d[k] = prv_dat[k];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= INI_DATA;
            end else begin
                vld_q[k] <= vld_d[k];
                dat_q[k] <= dat_d[k];
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CW'(vld_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oRdy = rdy[0] & ~flush;
    assign oVld = vld_q[DEPTH-1];
    assign oDat = dat_q[DEPTH-1];
    assign oCnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_zion_basic_circuit_lib_pipe_dff.sv
//==============================================================================
// Module   : tb_zion_basic_circuit_lib_pipe_dff
// Brief    : Scoreboard bench for the pipelined valid/ready register.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_zion_basic_circuit_lib_pipe_dff;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] INI   = 8'h5A;
    localparam int         CW    = $clog2(DEPTH + 1);

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          flush = 1'b0;
    logic          iVld  = 1'b0;
    logic          iRdy  = 1'b0;
    logic [7:0]    iDat  = 8'h00;
    logic          oRdy;
    logic          oVld;
    logic [7:0]    oDat;
    logic [CW-1:0] oCnt;

    always #5 clk = ~clk;

    zion_basic_circuit_lib_pipe_dff #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .INI_DATA (INI)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .iVld  (iVld),
        .oRdy  (oRdy),
        .iDat  (iDat),
        .oVld  (oVld),
        .iRdy  (iRdy),
        .oDat  (oDat),
        .oCnt  (oCnt)
    );

    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    int         checks    = 0;
    int         failures  = 0;
    int         cnt_model = 0;
    int         cyc       = 0;
    int         acc_cyc   = 0;
    bit         mon_cons  = 1'b0;
    bit         lat_arm   = 1'b0;
    bit         lat_set   = 1'b0;

    always @(negedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands a beat downstream.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            mon_cons = 1'b0;
            if (rst && oVld && iRdy) begin
                mon_cons = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %0h expected none (cycle %0d)", oDat, cyc);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("beat", {24'h0, oDat}, {24'h0, exp_v});
                    if (lat_arm) begin
                        chk("latency", cyc - acc_cyc, DEPTH);
                        lat_arm = 1'b0;
                    end
                end
            end
        end
    end

    // One bus cycle: drive at negedge, then check occupancy/ready and book the transfer.
    task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit f, output bit acc);
        bit mrdy;
        @(negedge clk);
        iVld  = v;
        iDat  = d;
        iRdy  = r;
        flush = f;
        #2;
        chk("oCnt", {{(32-CW){1'b0}}, oCnt}, cnt_model);
        mrdy = ((cnt_model < DEPTH) || r) && !f;
        chk("oRdy", {31'h0, oRdy}, {31'h0, mrdy});
        acc = v && mrdy;
        if (f) begin
            exp_q.delete();
            cnt_model = 0;
        end else begin
            cnt_model = cnt_model + int'(acc) - int'(mon_cons);
        end
        if (acc) begin
            exp_q.push_back(d);
            if (lat_arm && !lat_set) begin
                acc_cyc = cyc;
                lat_set = 1'b1;
            end
        end
    endtask

    initial begin
        bit         acc;
        bit         pend;
        logic [7:0] pd;

        // Reset asserted mid-clock takes effect immediately.
        #3 rst = 1'b0;
        #1;
        chk("rst_oVld", {31'h0, oVld}, 0);
        chk("rst_oDat", {24'h0, oDat}, {24'h0, INI});
        chk("rst_oCnt", {{(32-CW){1'b0}}, oCnt}, 0);
        chk("rst_oRdy", {31'h0, oRdy}, 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
            chk("idle_oVld", {31'h0, oVld}, 0);
        end

        // Streaming.
        lat_arm = 1'b1;
        lat_set = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0, acc);
        end
        chk("stream_cnt", {{(32-CW){1'b0}}, oCnt}, 3);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Back-pressure fill then release.
        cycle(1'b1, 8'hA1, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hA3, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hA4, 1'b0, 1'b0, acc);
        chk("bp_full_oRdy", {31'h0, oRdy}, 0);
        cycle(1'b1, 8'hA4, 1'b0, 1'b0, acc);
        chk("bp_full_cnt", {{(32-CW){1'b0}}, oCnt}, 3);
        chk("bp_hold_dat", {24'h0, oDat}, 32'hA1);
        cycle(1'b1, 8'hA4, 1'b1, 1'b0, acc);
        chk("bp_accept_a4", {31'h0, acc}, 1);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Bubble collapse with downstream stalled.
        cycle(1'b1, 8'hB1, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hB3, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("bub_cnt", {{(32-CW){1'b0}}, oCnt}, 3);
        chk("bub_oVld", {31'h0, oVld}, 1);
        chk("bub_oDat", {24'h0, oDat}, 32'hB1);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Flush with two beats in flight and a beat offered.
        cycle(1'b1, 8'hC1, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h77, 1'b0, 1'b1, acc);
        chk("fl_cnt_before", {{(32-CW){1'b0}}, oCnt}, 2);
        chk("fl_oRdy", {31'h0, oRdy}, 0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, acc);
        chk("fl_oVld_after", {31'h0, oVld}, 0);
        chk("fl_cnt_after", {{(32-CW){1'b0}}, oCnt}, 0);
        chk("fl_accept_77", {31'h0, acc}, 1);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Reset mid-stream drops in-flight beats without a clock.
        cycle(1'b1, 8'hD1, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hD2, 1'b0, 1'b0, acc);
        #1 rst = 1'b0;
        #1;
        chk("mrst_oVld", {31'h0, oVld}, 0);
        chk("mrst_oCnt", {{(32-CW){1'b0}}, oCnt}, 0);
        chk("mrst_oDat", {24'h0, oDat}, {24'h0, INI});
        exp_q.delete();
        cnt_model = 0;
        cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Random traffic; the source holds a refused beat until taken.
        pend = 1'b0;
        pd   = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pd   = 8'($urandom_range(0, 255));
            end
            cycle(pend, pend ? pd : 8'h00, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_oVld", {31'h0, oVld}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
